tmr_fault_monitor: RTL

Monitors the three replicas of a triplicated register (e.g. the TMR counters), produces the registered majority value, and classifies disagreements. A single-replica fault that persists is repaired: the monitor drives a one-cycle load strobe and the voted value back into the faulty replica. It sits beside the voter in the TMR top and closes the loop that external fault injection opens. It counts repairs and flags uncorrectable (no-majority) conditions.

---
 rtl/tmr_mon_pkg.sv | 40 ++++
 rtl/tmr_vote3.sv | 41 ++++
 rtl/tmr_fault_monitor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tmr_mon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tmr_mon_pkg : shared types for the TMR voter and fault monitor     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tmr_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONFIRM = 3'd1,
    REPAIR  = 3'd2,
    VERIFY  = 3'd3,
    FATAL   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    FI_NONE  = 3'd0,
    FI_R1    = 3'd1,
    FI_R2    = 3'd2,
    FI_R3    = 3'd3,
    FI_MULTI = 3'd4
  } fault_class_e;

  localparam logic [1:0] IDX_NONE = 2'd0;

  function automatic logic is_single(input fault_class_e c);
    return (c == FI_R1) || (c == FI_R2) || (c == FI_R3);
  endfunction

  function automatic logic [1:0] class_idx(input fault_class_e c);
    case (c)
      FI_R1:   return 2'd1;
      FI_R2:   return 2'd2;
      FI_R3:   return 2'd3;
      default: return IDX_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_vote3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tmr_vote3 : bitwise 2-of-3 majority and disagreement classifier    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tmr_vote3
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_vote,
  output fault_class_e     o_class
);

  logic w_ab;
  logic w_bc;
  logic w_ac;

  assign o_vote = (i_a & i_b) | (i_b & i_c) | (i_a & i_c);
  assign w_ab   = (i_a == i_b);
  assign w_bc   = (i_b == i_c);
  assign w_ac   = (i_a == i_c);

  // The odd one out is the replica absent from the only equal pair.
  always_comb begin
    o_class = FI_MULTI;
    if (w_ab && w_bc)
      o_class = FI_NONE;
    else if (w_ab)
      o_class = FI_R3;
    else if (w_ac)
      o_class = FI_R2;
    else if (w_bc)
      o_class = FI_R1;
  end

endmodule
`default_nettype wire

// File: rtl/tmr_fault_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tmr_fault_monitor : registered TMR vote, fault classification and  |
// | scrub-back repair. Optional TMR_FAULT_LOG_EN adds a fault log.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tmr_fault_monitor
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PERSIST   = 2,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  input  logic             clear_cnt,
  output logic [WIDTH-1:0] q_voted,
  output logic             fault_active,
  output logic [1:0]       fault_idx,
  output logic [2:0]       repair_load,
  output logic [WIDTH-1:0] repair_val,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             fatal
`ifdef TMR_FAULT_LOG_EN
  ,
  output logic [WIDTH-1:0] last_bad_val,
  output logic [1:0]       last_bad_idx
`endif
);

  // Headroom of one count so persist+1 never wraps, even when PERSIST==1.
  localparam int PW = $clog2(PERSIST + 2);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_vote;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;
  logic [PW-1:0]    r_persist;
  logic [PW-1:0]    w_persist_nxt;
  logic [PW-1:0]    w_persist_inc;
  logic [RW-1:0]    r_retry;
  logic [RW-1:0]    w_retry_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_vote;
  fault_class_e     w_class;
  logic             w_single;
  logic [1:0]       w_cls_idx;

  tmr_vote3 #(.WIDTH(WIDTH)) u_vote (
    .i_a     (q_1),
    .i_b     (q_2),
    .i_c     (q_3),
    .o_vote  (w_vote),
    .o_class (w_class)
  );

  assign w_single      = is_single(w_class);
  assign w_cls_idx     = class_idx(w_class);
  assign w_persist_inc = r_persist + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_persist_nxt = r_persist;
    w_retry_nxt   = r_retry;
    case (r_state)
      IDLE: begin
        if (w_class == FI_MULTI) begin
          w_state_nxt = FATAL;
        end else if (w_single) begin
          w_idx_nxt     = w_cls_idx;
          w_persist_nxt = PW'(1);
          w_state_nxt   = (PERSIST == 1) ? REPAIR : CONFIRM;
        end
      end
      CONFIRM: begin
        if (w_class == FI_MULTI) begin
          w_state_nxt = FATAL;
        end else if (!w_single) begin
          w_state_nxt   = IDLE;
          w_idx_nxt     = IDX_NONE;
          w_persist_nxt = '0;
        end else if (w_cls_idx == r_idx) begin
          w_persist_nxt = w_persist_inc;
          if (w_persist_inc >= PW'(PERSIST))
            w_state_nxt = REPAIR;
        end else begin
          w_idx_nxt     = w_cls_idx;
          w_persist_nxt = PW'(1);
          if (PERSIST == 1)
            w_state_nxt = REPAIR;
        end
      end
      REPAIR: begin
        w_state_nxt   = VERIFY;
        w_retry_nxt   = r_retry + RW'(1);
        w_persist_nxt = '0;
      end
      VERIFY: begin
        if (w_class == FI_MULTI) begin
          w_state_nxt = FATAL;
        end else if (!w_single) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = IDX_NONE;
          w_retry_nxt = '0;
        end else if (w_cls_idx == r_idx) begin
          w_state_nxt = (r_retry < RW'(MAX_RETRY)) ? REPAIR : FATAL;
        end else begin
          w_state_nxt   = CONFIRM;
          w_idx_nxt     = w_cls_idx;
          w_retry_nxt   = '0;
          w_persist_nxt = PW'(1);
        end
      end
      FATAL: begin
        w_state_nxt = FATAL;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vote    <= '0;
      r_idx     <= IDX_NONE;
      r_persist <= '0;
      r_retry   <= '0;
      r_cnt     <= '0;
    end else begin
      r_vote    <= w_vote;
      r_idx     <= w_idx_nxt;
      r_persist <= w_persist_nxt;
      r_retry   <= w_retry_nxt;
      // A clear in the same cycle as a repair discards that repair's count.
      if (clear_cnt)
        r_cnt <= '0;
      else if ((r_state == REPAIR) && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Strobe decodes straight from the state register so reset kills it at once.
  always_comb begin
    repair_load = 3'b000;
    repair_val  = '0;
    if (r_state == REPAIR) begin
      repair_val = w_vote;
      case (r_idx)
        2'd1:    repair_load = 3'b001;
        2'd2:    repair_load = 3'b010;
        2'd3:    repair_load = 3'b100;
        default: repair_load = 3'b000;
      endcase
    end
  end

  assign q_voted      = r_vote;
  assign fault_idx    = r_idx;
  assign fault_cnt    = r_cnt;
  assign fatal        = (r_state == FATAL);
  assign fault_active = (r_state == CONFIRM) || (r_state == REPAIR) || (r_state == VERIFY);

`ifdef TMR_FAULT_LOG_EN
  logic [WIDTH-1:0] r_bad_val;
  logic [1:0]       r_bad_idx;
  logic [WIDTH-1:0] w_bad_val;

  always_comb begin
    case (w_idx_nxt)
      2'd1:    w_bad_val = q_1;
      2'd2:    w_bad_val = q_2;
      2'd3:    w_bad_val = q_3;
      default: w_bad_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bad_val <= '0;
      r_bad_idx <= IDX_NONE;
    end else if (clear_cnt) begin
      r_bad_val <= '0;
      r_bad_idx <= IDX_NONE;
    end else if ((w_state_nxt == REPAIR) && (r_state != REPAIR)) begin
      r_bad_val <= w_bad_val;
      r_bad_idx <= w_idx_nxt;
    end
  end

  assign last_bad_val = r_bad_val;
  assign last_bad_idx = r_bad_idx;
`endif

endmodule
`default_nettype wire
